fu_wb_queue: RTL

FU_WB_QUEUE -- requirements
Module: fu_wb_queue

---
 rtl/rv32i_types.sv | 14 +
 rtl/fu_wb_queue_if.sv | 35 +++
 rtl/fu_wb_queue.sv | 71 +++++++
 3 files changed

// File: rtl/rv32i_types.sv
// Shared out-of-order core types: the instruction record passed from a
// functional unit towards writeback, and the ROB tag width it carries.
package rv32i_types;

    localparam int ROB_NUM_BITS = 5;

    typedef struct packed {
        logic                    valid;
        logic [ROB_NUM_BITS-1:0] rob_addr;
        logic [4:0]              rd_addr;
        logic [31:0]             rd_data;
    } ooo_instr_t;

endpackage

// File: rtl/fu_wb_queue_if.sv
// Handshake bundle between one functional unit, its result queue and the
// writeback arbiter. The queue uses the slave view; the surroundings drive
// through the master view.
interface fu_wb_queue_if
    import rv32i_types::*;
#(
    parameter int DEPTH = 4
);

    logic                     flush;
    ooo_instr_t               fu_in;
    logic                     fu_ready;
    ooo_instr_t               wb_out;
    logic                     wb_resp;
    logic [$clog2(DEPTH):0]   count;

    modport slave (
        input  flush,
        input  fu_in,
        output fu_ready,
        output wb_out,
        input  wb_resp,
        output count
    );

    modport master (
        output flush,
        output fu_in,
        input  fu_ready,
        input  wb_out,
        output wb_resp,
        input  count
    );

endinterface

// File: rtl/fu_wb_queue.sv
// Completed-result queue sitting between a functional unit and the
// writeback arbiter. Results are held in a circular buffer and leave in
// acceptance order; flush squashes everything on a mispredict.
module fu_wb_queue
    import rv32i_types::*;
#(
    parameter int DEPTH = 4
) (
    input logic            clk,
    input logic            rst,
    fu_wb_queue_if.slave   bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    ooo_instr_t       entries [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   occupancy;

    logic push;
    logic pop;

    // Readiness depends only on registered occupancy, never on the grant,
    // so the functional unit sees no combinational path through the arbiter.
    assign bus.fu_ready = (occupancy != FULL_COUNT);
    assign bus.count    = occupancy;

    assign push = bus.fu_in.valid && bus.fu_ready && !bus.flush;
    assign pop  = bus.wb_resp && (occupancy != '0) && !bus.flush;

    // Present the oldest entry; an empty queue shows an all-zero record so
    // stale storage is never visible.
    always_comb begin
        bus.wb_out = '0;
        if (occupancy != '0) begin
            bus.wb_out       = entries[head];
            bus.wb_out.valid = 1'b1;
        end
    end

    // Entry storage is written on accept only and deliberately not reset.
    always_ff @(posedge clk) begin
        if (push) begin
            entries[tail] <= bus.fu_in;
        end
    end

    // Pointer and occupancy bookkeeping; reset beats flush beats push/pop.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            head      <= '0;
            tail      <= '0;
            occupancy <= '0;
        end else begin
            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            if (push && !pop) begin
                occupancy <= occupancy + 1'b1;
            end else if (pop && !push) begin
                occupancy <= occupancy - 1'b1;
            end
        end
    end

endmodule
